// File: rtl/acc_pkg.sv
// Shared widths, FSM state encoding and requester-id type for the nibble-serial accumulator sequencer.
package acc_pkg;

    localparam int unsigned WIDTH       = 16;
    localparam int unsigned NIBBLE      = 4;
    localparam int unsigned NUM_NIBBLES = 4;
    localparam int unsigned CNT_W       = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef logic req_id_t;

    // Select nibble idx (0 = least significant) of a full-width word.
    function automatic logic [NIBBLE-1:0] nibble_of(input logic [WIDTH-1:0] w,
                                                    input logic [CNT_W-1:0] idx);
        return w[{idx, 2'b00} +: NIBBLE];
    endfunction

endpackage

// File: rtl/adder_4.sv
// Plain 4-bit ripple adder with carry in/out; the only arithmetic element of the sequencer.
module adder_4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    assign {cout, sum} = 5'(a) + 5'(b) + 5'(cin);

endmodule

// File: rtl/acc_sequencer.sv
// Two-requester 16-bit add/subtract sequencer that reuses one 4-bit adder over four cycles.
// Optional macro ACC_RR_ARB_EN selects round-robin arbitration instead of fixed requester-0 priority.
module acc_sequencer
    import acc_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  req,
    input  logic [1:0]  sub,
    input  logic [15:0] a0,
    input  logic [15:0] b0,
    input  logic [15:0] a1,
    input  logic [15:0] b1,
    output logic [1:0]  gnt,
    output logic        busy,
    output logic        done,
    output logic        done_id,
    output logic [15:0] result,
    output logic        cout
);

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   op_a;
    logic [WIDTH-1:0]   op_b;
    logic [WIDTH-1:0]   shadow;
    logic               op_sub;
    logic               carry;
    req_id_t            op_id;
    req_id_t            pick_c;

    logic [NIBBLE-1:0]  nib_a_c;
    logic [NIBBLE-1:0]  nib_b_c;
    logic [NIBBLE-1:0]  nib_sum_c;
    logic               nib_cin_c;
    logic               nib_cout_c;

`ifdef ACC_RR_ARB_EN
    req_id_t            last_id;

    // On a tie, favour whichever requester was not served last.
    always_comb begin
        pick_c = 1'b0;
        if (req == 2'b11) begin
            pick_c = ~last_id;
        end else begin
            pick_c = req[1];
        end
    end
`else
    // Requester 0 wins whenever it is asking.
    always_comb begin
        pick_c = 1'b0;
        if (!req[0]) begin
            pick_c = 1'b1;
        end
    end
`endif

    // Subtract is a + ~b with carry-in 1 on the first nibble.
    assign nib_a_c   = nibble_of(op_a, cnt);
    assign nib_b_c   = nibble_of(op_b, cnt) ^ {NIBBLE{op_sub}};
    assign nib_cin_c = (cnt == '0) ? op_sub : carry;

    adder_4 u_adder (
        .a    (nib_a_c),
        .b    (nib_b_c),
        .cin  (nib_cin_c),
        .sum  (nib_sum_c),
        .cout (nib_cout_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            op_a    <= '0;
            op_b    <= '0;
            op_sub  <= 1'b0;
            op_id   <= 1'b0;
            carry   <= 1'b0;
            shadow  <= '0;
            gnt     <= 2'b00;
            busy    <= 1'b0;
            done    <= 1'b0;
            done_id <= 1'b0;
            result  <= '0;
            cout    <= 1'b0;
`ifdef ACC_RR_ARB_EN
            last_id <= 1'b1;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req != 2'b00) begin
                        op_id  <= pick_c;
                        op_a   <= pick_c ? a1 : a0;
                        op_b   <= pick_c ? b1 : b0;
                        op_sub <= sub[pick_c];
                        gnt    <= pick_c ? 2'b10 : 2'b01;
                        busy   <= 1'b1;
                        cnt    <= '0;
                        state  <= ST_RUN;
`ifdef ACC_RR_ARB_EN
                        last_id <= pick_c;
`endif
                    end
                end
                ST_RUN: begin
                    shadow[{cnt, 2'b00} +: NIBBLE] <= nib_sum_c;
                    carry <= nib_cout_c;
                    if (cnt == CNT_W'(NUM_NIBBLES - 1)) begin
                        state <= ST_DONE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    done    <= 1'b1;
                    done_id <= op_id;
                    result  <= shadow;
                    cout    <= carry;
                    gnt     <= 2'b00;
                    busy    <= 1'b0;
                    cnt     <= '0;
                    state   <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
